code_lock_ctrl: RTL
===================

// Module: code_lock_ctrl
// PURPOSE
//  Parametrised keypad combination-lock controller; successor to the fixed 4-digit checker.
//  - Collects CODE_LEN decimal digits from the keypad scanner and compares the whole sequence at once.
//  - Holds `open` until relocked; the code is reprogrammable while open.
//  - Enters timed lockout after MAX_FAILS consecutive wrong codes.
//  - Sits between the keypad decoder (keycode) and the door/LED outputs.
// PARAMETERS
//  CODE_LEN        4         digits per code (1..8)
//  DEFAULT_CODE    16'h1296  reset code, BCD, 4*CODE_LEN bits; first digit in the MS nibble
//  MAX_FAILS       3         consecutive wrong codes before lockout (>=1)
//  LOCKOUT_CYCLES  1000      clk5 cycles spent in LOCKOUT (>=1)
// PORTS
//  clk5          in   1                     system clock, rising edge
//  reset         in   1                     asynchronous, active-high
//  keycode       in   5                     [4]=key valid, [3:0]=key value (0-9 digits, A/B/C/D-F)
//  open          out  1                     high while state==OPEN
//  fail          out  1                     1-cycle pulse per wrong complete code
//  locked_out    out  1                     high while state==LOCKOUT
//  prog_mode     out  1                     high while state==PROG
//  digit_count   out  $clog2(CODE_LEN+1)    digits held in the entry buffer
// BEHAVIOUR
//  Press detect:
//  - kc_q <= keycode every cycle; reset value 5'b00000.
//  - press = keycode[4] && (keycode != kc_q); a held key counts once.
//  - A different valid key with no release in between is a new press.
//  States ENTRY, OPEN, PROG, LOCKOUT. Reset: ENTRY, buffer/count/fails/timer=0, code=DEFAULT_CODE, all outputs 0.
//  ENTRY:
//  - Digit press (0-9): shifted into buffer, count+1.
//  - Press of C: count=0, buffer cleared.
//  - Other keys: ignored.
//  - Edge accepting the CODE_LEN-th digit compares {buffer,digit} to code; count->0 on that edge.
//    Match: ->OPEN, fails=0; open high the next cycle (1-cycle latency).
//    Mismatch: fail pulses the next cycle; fails+1; if fails+1==MAX_FAILS ->LOCKOUT, timer=LOCKOUT_CYCLES-1, else stay in ENTRY.
//  OPEN:
//  - B -> ENTRY (open drops next cycle).
//  - A -> PROG with count=0.
//  - Digits and C ignored.
//  PROG:
//  - Digits collected as in ENTRY.
//  - On the CODE_LEN-th digit: code <= new sequence, ->ENTRY (locked with new code).
//  - C aborts: ->OPEN, code unchanged, count=0.
//  - A/B/D-F ignored.
//  LOCKOUT:
//  - All keys ignored, including C.
//  - Timer decrements each cycle; at 0 ->ENTRY with fails=0 and count=0.
//  - locked_out is high for exactly LOCKOUT_CYCLES cycles.
//  Widths and counters:
//  - fails saturates at MAX_FAILS.
//  - Timer width $clog2(LOCKOUT_CYCLES).
//  - digit_count never exceeds CODE_LEN-1 when observed; it wraps to 0 on completion.
//  Simultaneous events: press detection has priority over nothing; reset overrides everything, and asserting it mid-entry/PROG/LOCKOUT loses all progress and restores DEFAULT_CODE.
//  Stored code survives relock and lockout.
// STRUCTURE
//  - Package code_lock_pkg: KEY_VALID_BIT=4, KEY_CLEAR=4'hC, KEY_RELOCK=4'hB, KEY_PROG=4'hA, state encoding (2 bits), is_digit() function.
//  - Sub-module key_press_detect (clk5, reset, keycode -> press, key[3:0]) holds kc_q and the edge logic.
//  - Top holds the FSM, entry shift register, code register, fail counter and lockout timer.
// TESTING
//  - Reset, hold 5'b10001 10 cycles then release -> digit_count=1 (single press); open=0.
//  - Presses 1,2,9,6 -> open=1 one cycle after the '6' edge; fail never pulses; B -> open=0 next cycle.
//  - Presses 1,2,C,1,2,9,6 -> clear honoured, open=1; digit_count shows 2 then 0 after C.
//  - Three wrong codes (0000) -> fail pulses x3, locked_out=1 for exactly 1000 cycles.
//    Correct code during lockout -> ignored; after expiry the correct code opens.
//  - Open, A, 4,3,2,1 -> prog_mode=1 then 0, state ENTRY.
//    1296 -> fail; 4321 -> open; reset -> 1296 opens again.
//  - Open, A, 4,3, C -> back to OPEN, code still 1296; reset asserted mid-PROG -> all outputs 0.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared key codes, FSM state type and digit classifier for the keypad code lock.
package code_lock_pkg;

  localparam int         KEY_VALID_BIT = 4;
  localparam logic [3:0] KEY_CLEAR     = 4'hC;
  localparam logic [3:0] KEY_RELOCK    = 4'hB;
  localparam logic [3:0] KEY_PROG      = 4'hA;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_PROG    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// Keypad-to-lock signal bundle: keypad side is master, lock controller is slave.
interface code_lock_ctrl_if #(
  parameter int CODE_LEN = 4
);
  localparam int CW = $clog2(CODE_LEN + 1);

  logic [4:0]    keycode;
  logic          open;
  logic          fail;
  logic          locked_out;
  logic          prog_mode;
  logic [CW-1:0] digit_count;

  modport master (
    output keycode,
    input  open, fail, locked_out, prog_mode, digit_count
  );

  modport slave (
    input  keycode,
    output open, fail, locked_out, prog_mode, digit_count
  );
endinterface

// File: rtl/key_press_detect.sv
// Turns the level keycode from the scanner into single-cycle press events.
module key_press_detect
  import code_lock_pkg::*;
(
  input  logic       clk5,
  input  logic       reset,
  input  logic [4:0] keycode,
  output logic       press,
  output logic [3:0] key
);

  logic [4:0] kc_q, kc_d;

  always_comb kc_d = keycode;

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) kc_q <= '0;
    else       kc_q <= kc_d;
  end

  // Any change to a valid code is a press, so rolling between keys counts too.
  assign press = keycode[KEY_VALID_BIT] && (keycode != kc_q);
  assign key   = keycode[3:0];

endmodule

// File: rtl/code_lock_ctrl.sv
// Combination-lock FSM: digit entry, open/relock, code programming and timed lockout.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int                      CODE_LEN       = 4,
  parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h1296,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 1000
) (
  input  logic            clk5,
  input  logic            reset,
  code_lock_ctrl_if.slave bus
);

  localparam int BW = 4 * CODE_LEN;
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic       press;
  logic [3:0] key;

  key_press_detect u_press (
    .clk5    (clk5),
    .reset   (reset),
    .keycode (bus.keycode),
    .press   (press),
    .key     (key)
  );

  state_t        state_q, state_d;
  logic [BW-1:0] entry_q, entry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] code_q, code_d;
  logic [FW-1:0] fails_q, fails_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          fail_q, fail_d;

  logic [BW-1:0] new_seq;
  logic          last_digit;
  logic          digit_press;

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    fails_d     = fails_q;
    timer_d     = timer_q;
    fail_d      = 1'b0;
    // Shifting left drops the oldest nibble, leaving the last CODE_LEN digits.
    new_seq     = (entry_q << 4) | BW'(key);
    last_digit  = (cnt_q == CW'(CODE_LEN - 1));
    digit_press = press && is_digit(key);

    case (state_q)
      ST_ENTRY: begin
        if (digit_press) begin
          if (last_digit) begin
            cnt_d   = '0;
            entry_d = '0;
            if (new_seq == code_q) begin
              state_d = ST_OPEN;
              fails_d = '0;
            end else begin
              fail_d = 1'b1;
              if (int'(fails_q) + 1 >= MAX_FAILS) begin
                fails_d = FW'(MAX_FAILS);
                state_d = ST_LOCKOUT;
                timer_d = TW'(LOCKOUT_CYCLES - 1);
              end else begin
                fails_d = fails_q + FW'(1);
              end
            end
          end else begin
            entry_d = new_seq;
            cnt_d   = cnt_q + CW'(1);
          end
        end else if (press && key == KEY_CLEAR) begin
          cnt_d   = '0;
          entry_d = '0;
        end
      end

      ST_OPEN: begin
        if (press && key == KEY_RELOCK) begin
          state_d = ST_ENTRY;
        end else if (press && key == KEY_PROG) begin
          state_d = ST_PROG;
          cnt_d   = '0;
          entry_d = '0;
        end
      end

      ST_PROG: begin
        if (digit_press) begin
          if (last_digit) begin
            code_d  = new_seq;
            state_d = ST_ENTRY;
            cnt_d   = '0;
            entry_d = '0;
          end else begin
            entry_d = new_seq;
            cnt_d   = cnt_q + CW'(1);
          end
        end else if (press && key == KEY_CLEAR) begin
          state_d = ST_OPEN;
          cnt_d   = '0;
          entry_d = '0;
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_ENTRY;
          fails_d = '0;
          cnt_d   = '0;
          entry_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state_q <= ST_ENTRY;
      entry_q <= '0;
      cnt_q   <= '0;
      code_q  <= DEFAULT_CODE;
      fails_q <= '0;
      timer_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      fails_q <= fails_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.open        = (state_q == ST_OPEN);
  assign bus.fail        = fail_q;
  assign bus.locked_out  = (state_q == ST_LOCKOUT);
  assign bus.prog_mode   = (state_q == ST_PROG);
  assign bus.digit_count = cnt_q;

endmodule
